// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data, shared memory port and stall signals of the arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_funct3;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_funct3;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_mem;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_rdata,
        input  if_rdata, if_valid, d_rdata, d_valid, mem_en, mem_we, mem_addr, mem_wdata,
               mem_funct3, stall_if, stall_mem
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_rdata,
        output if_rdata, if_valid, d_rdata, d_valid, mem_en, mem_we, mem_addr, mem_wdata,
               mem_funct3, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters
module mem_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input logic clk,
    input logic reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

    state_t            state, state_n;
    logic [3:0]        wait_cnt;
    logic [2:0]        streak;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        funct3_q;
    logic              we_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              if_valid_q, d_valid_q;
    logic              if_m, d_m, grant_i, grant_d, done;

    // a requester is ignored during the cycle its previous access reports completion
    assign if_m = bus.if_req & ~if_valid_q;
    assign d_m  = bus.d_req & ~d_valid_q;
    assign done = (state != IDLE) && (wait_cnt == 4'd0);

    // arbitration: data wins unless four data grants in a row have starved a waiting fetch
    always_comb begin
        state_n = state;
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            grant_i = if_m && (streak[2] || !d_m);
            grant_d = d_m && !grant_i;
            state_n = grant_d ? DACC : grant_i ? IACC : IDLE;
        end else if (wait_cnt == 4'd0) begin
            state_n = IDLE;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // command latch, wait and streak counters, read data capture and completion pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt   <= '0;
            streak     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
        end else begin
            if_valid_q <= done && state == IACC;
            d_valid_q  <= done && state == DACC;
            if (grant_i || grant_d) begin
                wait_cnt <= 4'(MEM_LAT - 1);
                addr_q   <= grant_d ? bus.d_addr : bus.if_addr;
                wdata_q  <= grant_d ? bus.d_wdata : '0;
                funct3_q <= grant_d ? bus.d_funct3 : 3'b010;
                we_q     <= grant_d & bus.d_we;
                streak   <= (grant_d && bus.if_req) ? streak + 3'd1 : 3'd0;
            end else if (state != IDLE && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (done && state == IACC) if_rdata_q <= bus.mem_rdata;
            if (done && state == DACC && !we_q) d_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.mem_en     = state != IDLE;
    assign bus.mem_we     = state == DACC && we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_funct3 = funct3_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.if_valid   = if_valid_q;
    assign bus.d_valid    = d_valid_q;
    assign bus.stall_if   = bus.if_req & ~if_valid_q;
    assign bus.stall_mem  = bus.d_req & ~d_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random traffic into two arbiters (MEM_LAT 2 and 1) against a scoreboard model
module tb_mem_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [2:0]    d_funct3 = '0;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 2 : 1;

        typedef struct {
            bit            d;
            logic [DW-1:0] data;
            int            due;
        } exp_t;

        mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
            .clk(clk), .reset(reset), .bus(bus)
        );

        logic [DW-1:0] tmem [1<<AW];
        logic [DW-1:0] mmem [1<<AW];
        exp_t          q[$];
        int            cyc = 0, busy = 0, streak = 0;
        bit            mvi = 0, mvd = 0, cd = 0, cwe = 0;
        logic [AW-1:0] caddr = '0;
        logic [DW-1:0] cwd = '0, cdata = '0, ird = '0, drd = '0;
        logic [2:0]    cf = '0;

        assign bus.if_req    = if_req;
        assign bus.if_addr   = if_addr;
        assign bus.d_req     = d_req;
        assign bus.d_we      = d_we;
        assign bus.d_addr    = d_addr;
        assign bus.d_wdata   = d_wdata;
        assign bus.d_funct3  = d_funct3;
        assign bus.mem_rdata = tmem[bus.mem_addr];

        initial begin
            for (int i = 0; i < (1 << AW); i++) begin
                logic [DW-1:0] v;
                v = (i == 4) ? 32'h00500093 : $urandom;
                tmem[i] = v;
                mmem[i] = v;
            end
        end

        always @(posedge clk) if (bus.mem_we) tmem[bus.mem_addr] <= bus.mem_wdata;

        // reference model: whole-transaction view, one access at a time, expectations queued at grant
        always @(posedge clk) begin
            bit vi, vd, im, dm;
            vi = mvi;
            vd = mvd;
            mvi = 0;
            mvd = 0;
            cyc++;
            if (reset) begin
                busy = 0;
                streak = 0;
                ird = '0;
                drd = '0;
                q.delete();
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    if (cd) begin
                        mvd = 1;
                        if (!cwe) drd = cdata;
                    end else begin
                        mvi = 1;
                        ird = cdata;
                    end
                end
            end else begin
                im = if_req && !vi;
                dm = d_req && !vd;
                if (dm && !(streak >= 4 && im)) begin
                    cd = 1; cwe = d_we; caddr = d_addr; cwd = d_wdata; cf = d_funct3;
                    streak = if_req ? streak + 1 : 0;
                    if (d_we) mmem[d_addr] = d_wdata;
                    cdata = d_we ? drd : mmem[d_addr];
                    busy = LAT;
                    q.push_back('{1'b1, cdata, cyc + LAT});
                end else if (im) begin
                    cd = 0; cwe = 0; caddr = if_addr; cwd = '0; cf = 3'b010;
                    streak = 0;
                    cdata = mmem[if_addr];
                    busy = LAT;
                    q.push_back('{1'b0, cdata, cyc + LAT});
                end
            end
        end

        // monitor: sample after the edge, compare port state and pop the scoreboard on each valid
        always begin
            exp_t e;
            @(posedge clk);
            #1;
            chk("mem_en", bus.mem_en, busy > 0);
            chk("mem_we", bus.mem_we, busy > 0 && cd && cwe);
            if (busy > 0) begin
                chk("mem_addr", bus.mem_addr, caddr);
                chk("mem_wdata", bus.mem_wdata, cwd);
                chk("mem_funct3", bus.mem_funct3, cf);
            end
            chk("if_rdata", bus.if_rdata, ird);
            chk("d_rdata", bus.d_rdata, drd);
            chk("if_valid", bus.if_valid, mvi);
            chk("d_valid", bus.d_valid, mvd);
            chk("stall_if", bus.stall_if, if_req && !mvi);
            chk("stall_mem", bus.stall_mem, d_req && !mvd);
            if (bus.if_valid || bus.d_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", {bus.if_valid, bus.d_valid}, 2'b00);
                end else begin
                    e = q.pop_front();
                    chk("valid_kind", {bus.if_valid, bus.d_valid}, e.d ? 2'b01 : 2'b10);
                    chk("valid_cycle", cyc, e.due);
                    chk("valid_rdata", e.d ? bus.d_rdata : bus.if_rdata, e.data);
                end
            end
        end
    end

    // stimulus: phases of random request/drop rates with occasional mid-traffic resets
    initial begin
        int rise [5] = '{30, 100, 10, 60, 100};
        int drop [5] = '{20, 0, 50, 5, 0};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        if_req = 1'b1;
        if_addr = 9'h004;
        repeat (4) @(negedge clk);
        if_req = 1'b0;
        repeat (4) @(negedge clk);
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                reset = ($urandom_range(199) == 0);
                if (!if_req) begin
                    if_req = ($urandom_range(99) < rise[p]);
                    if_addr = AW'($urandom);
                end else begin
                    if ($urandom_range(99) < drop[p]) if_req = 1'b0;
                    if ($urandom_range(9) == 0) if_addr = AW'($urandom);
                end
                if (!d_req) begin
                    d_req = ($urandom_range(99) < rise[p]);
                    d_we = (p == 4) ? 1'b1 : 1'($urandom);
                    d_addr = AW'($urandom_range(31));
                    d_wdata = $urandom;
                    d_funct3 = 3'($urandom);
                end else begin
                    if ($urandom_range(99) < drop[p]) d_req = 1'b0;
                    if ($urandom_range(9) == 0) d_addr = AW'($urandom_range(31));
                end
            end
        end
        reset = 1'b0;
        if_req = 1'b0;
        d_req = 1'b0;
        repeat (40) @(negedge clk);
        chk("drain_lat2", lane[0].q.size(), 0);
        chk("drain_lat1", lane[1].q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
